mem_arbiter: RTL and testbench

- Shares the single-ported RAM between the instruction-fetch port and the data port of the pipelined CPU.
- Sequences each access with a small FSM and hides RAM wait states behind per-port wait signals.
- Owns the LL/SC link register, so atomic data accesses (`datomic`) resolve here.
- Sits between the caches/datapath memory interface and the RAM model.

---
 rtl/cpu_types_pkg.sv | 22 ++
 rtl/llsc_link_reg.sv | 30 +++
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-interface types: word type, RAM status, arbiter FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DACC = 2'b01,
    IACC = 2'b10
  } arb_state_t;

  // Load value handed back when the RAM flags an access as failed.
  localparam word_t ERR_WORD_DEFAULT = 32'hBAD1_BAD1;

endpackage

// File: rtl/llsc_link_reg.sv
// LL/SC reservation: remembers one linked word address and whether it is still valid.
module llsc_link_reg
  import cpu_types_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  set,
  input  logic  clr,
  input  word_t addr,
  output logic  match
);

  logic  valid_q;
  word_t addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else if (set) begin
      valid_q <= 1'b1;
      addr_q  <= addr;
    end else if (clr) begin
      valid_q <= 1'b0;
    end
  end

  assign match = valid_q && (addr_q == addr);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-ported RAM between instruction fetch and data ports,
// with data priority bounded by a starvation counter and LL/SC resolution.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4,
  parameter word_t       ERR_WORD   = ERR_WORD_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic        datomic,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  ramstate_t   ramstate
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] StarveLimit = CntW'(STARVE_MAX);

  arb_state_t      state_q, state_d;
  logic [CntW-1:0] starve_q, starve_d;

  logic dreq, sc_req, ll_req;
  logic link_set, link_clr, link_match;

  assign dreq   = dREN | dWEN;
  assign sc_req = dWEN & datomic;
  assign ll_req = dREN & ~dWEN & datomic;

  llsc_link_reg u_link (
    .clk   (CLK),
    .rst   (RST),
    .set   (link_set),
    .clr   (link_clr),
    .addr  (daddr),
    .match (link_match)
  );

  always_comb begin
    state_d  = state_q;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    link_set = 1'b0;
    link_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dreq && !(iREN && starve_q == StarveLimit)) begin
          state_d = DACC;
        end else if (iREN) begin
          state_d = IACC;
        end
      end
      IACC: begin
        if (!iREN) begin
          state_d = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (ramstate == ACCESS) begin
            iwait   = 1'b0;
            iload   = ramload;
            state_d = IDLE;
          end else if (ramstate == ERROR) begin
            iwait   = 1'b0;
            iload   = ERR_WORD;
            state_d = IDLE;
          end
        end
      end
      DACC: begin
        if (!dreq) begin
          state_d = IDLE;
        end else if (sc_req && !link_match) begin
          // Failed SC resolves without touching the RAM.
          dwait   = 1'b0;
          state_d = IDLE;
        end else begin
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          ramaddr  = daddr;
          ramstore = dstore;
          if (ramstate == ACCESS) begin
            dwait    = 1'b0;
            dload    = dWEN ? {31'b0, datomic} : ramload;
            state_d  = IDLE;
            link_set = ll_req;
            link_clr = dWEN & link_match;
          end else if (ramstate == ERROR) begin
            dwait    = 1'b0;
            dload    = ERR_WORD;
            state_d  = IDLE;
            link_clr = dWEN & ~datomic & link_match;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (!iREN) begin
      starve_d = '0;
    end else if (state_q == IDLE && state_d == IACC) begin
      starve_d = '0;
    end else if (state_q == IDLE && state_d == DACC && starve_q != StarveLimit) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: simple RAM model plus expected-value queues.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN, datomic;
  logic [31:0] iaddr, daddr, dstore;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore, ramload;
  ramstate_t   ramstate;

  mem_arbiter dut (
    .CLK      (CLK),
    .RST      (RST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .datomic  (datomic),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate)
  );

  always #5 CLK = ~CLK;

  // RAM model: read-only preloaded contents, configurable BUSY count and error injection.
  logic [31:0] mem [0:255];
  int          busy_n;
  int          busy_cnt;
  bit          ram_err;
  logic [31:0] last_wa, last_wd;
  int          wen_cyc;

  assign ramload = mem[ramaddr[11:4]];

  always_comb begin
    ramstate = FREE;
    if (ramREN || ramWEN) begin
      if (busy_cnt < busy_n) ramstate = BUSY;
      else                   ramstate = ram_err ? ERROR : ACCESS;
    end
  end

  always @(posedge CLK) begin
    if ((ramREN || ramWEN) && ramstate == BUSY) busy_cnt <= busy_cnt + 1;
    else                                        busy_cnt <= 0;
    if (ramWEN) wen_cyc <= wen_cyc + 1;
    if (ramWEN && ramstate == ACCESS) begin
      last_wa <= ramaddr;
      last_wd <= ramstore;
    end
  end

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] iq [$];
  logic [31:0] dq [$];
  int          gq [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Wait for the instruction port to complete; k counts cycles since the request was driven.
  task automatic await_i(input string tag, input int exp_lat);
    int  k = 0;
    bit  done = 0;
    while (!done && k < 30) begin
      @(negedge CLK);
      if (!iwait) begin
        done = 1;
        if (exp_lat >= 0) chk({tag, "_lat"}, k, exp_lat);
        if (iq.size() > 0) chk({tag, "_iload"}, iload, iq.pop_front());
      end
      cyc();
      k++;
    end
    if (!done) chk({tag, "_timeout"}, {31'b0, iwait}, 32'd0);
  endtask

  task automatic await_d(input string tag, input int exp_lat, input bit chk_data);
    int  k = 0;
    bit  done = 0;
    while (!done && k < 30) begin
      @(negedge CLK);
      if (!dwait) begin
        done = 1;
        if (exp_lat >= 0) chk({tag, "_lat"}, k, exp_lat);
        if (chk_data && dq.size() > 0) chk({tag, "_dload"}, dload, dq.pop_front());
      end
      cyc();
      k++;
    end
    if (!done) chk({tag, "_timeout"}, {31'b0, dwait}, 32'd0);
  endtask

  initial begin
    int k;
    int ng;
    int g;
    int w0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
    mem[8'h04] = 32'h8C22_0004;  // 0x40
    mem[8'h10] = 32'h0000_1234;  // 0x100
    busy_n = 0; busy_cnt = 0; ram_err = 0; wen_cyc = 0;
    last_wa = '0; last_wd = '0;
    RST = 1; iREN = 0; dREN = 0; dWEN = 0; datomic = 0;
    iaddr = '0; daddr = '0; dstore = '0;
    repeat (2) cyc();
    RST = 0;

    // Idle after reset.
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk($sformatf("idle%0d_waits_en", c), {28'b0, iwait, dwait, ramREN, ramWEN}, 32'hC);
      chk($sformatf("idle%0d_ramaddr", c), ramaddr, 32'd0);
      chk($sformatf("idle%0d_loads", c), iload | dload | ramstore, 32'd0);
      cyc();
    end

    // Instruction fetch with two BUSY cycles.
    busy_n = 2;
    iREN = 1; iaddr = 32'h40;
    iq.push_back(32'h8C22_0004);
    await_i("ifetch", 3);
    iREN = 0;
    busy_n = 0;
    cyc();

    // Both ports hammering: data wins four times, then instruction gets one grant.
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < 4; j++) gq.push_back(0);
      gq.push_back(1);
    end
    iREN = 1; iaddr = 32'h80;
    dREN = 1; daddr = 32'h200;
    k = 0; ng = 0;
    while (gq.size() > 0 && k < 60) begin
      @(negedge CLK);
      if (!iwait || !dwait) begin
        g = !iwait ? 1 : 0;
        chk($sformatf("grant%0d", ng), g, gq.pop_front());
        ng++;
      end
      cyc();
      k++;
    end
    if (gq.size() > 0) chk("grant_timeout", gq.size(), 0);
    iREN = 0; dREN = 0;
    cyc();

    // LL then SC to the same address succeeds and writes the RAM.
    dREN = 1; datomic = 1; daddr = 32'h100;
    dq.push_back(32'h0000_1234);
    await_d("ll1", 1, 1);
    dREN = 0;
    cyc();
    dWEN = 1; dstore = 32'd5;
    dq.push_back(32'd1);
    await_d("sc1", 1, 1);
    dWEN = 0;
    chk("sc1_wr_addr", last_wa, 32'h100);
    chk("sc1_wr_data", last_wd, 32'd5);
    cyc();

    // Second SC without a fresh LL fails immediately with no RAM write.
    w0 = wen_cyc;
    dWEN = 1; dstore = 32'd6;
    dq.push_back(32'd0);
    await_d("sc2", 1, 1);
    dWEN = 0;
    chk("sc2_no_wen", wen_cyc, w0);
    cyc();

    // An intervening plain write to the linked word breaks the reservation.
    dREN = 1; datomic = 1; daddr = 32'h100;
    await_d("ll3", 1, 0);
    dREN = 0; datomic = 0;
    cyc();
    dWEN = 1; dstore = 32'd7;
    await_d("wr3", 1, 0);
    chk("wr3_data", last_wd, 32'd7);
    dWEN = 0;
    cyc();
    w0 = wen_cyc;
    dWEN = 1; datomic = 1; dstore = 32'd8;
    dq.push_back(32'd0);
    await_d("sc3", 1, 1);
    dWEN = 0; datomic = 0;
    chk("sc3_no_wen", wen_cyc, w0);
    cyc();

    // RAM error during a data read returns the error word for a single cycle.
    ram_err = 1;
    dREN = 1; daddr = 32'h300;
    dq.push_back(32'hBAD1_BAD1);
    await_d("derr", 1, 1);
    dREN = 0;
    @(negedge CLK);
    chk("derr_one_cycle", {31'b0, dwait}, 32'd1);
    cyc();
    ram_err = 0;

    // Requester drops dREN after grant: enables fall, no completion appears.
    busy_n = 5;
    dREN = 1; daddr = 32'h400;
    @(negedge CLK);
    chk("abort_req_wait", {31'b0, dwait}, 32'd1);
    cyc();
    @(negedge CLK);
    chk("abort_granted_ren", {31'b0, ramREN}, 32'd1);
    cyc();
    dREN = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk($sformatf("abort%0d_wait_en", c), {30'b0, dwait, ramREN}, 32'd2);
      cyc();
    end
    busy_n = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
